// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator that turns byte/half/word accesses into
// word-aligned memory transactions, splitting word-crossing accesses and extending load data.
module load_store_unit #(
   parameter bit ALLOW_SPLIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   state_t state, state_nx;
   logic we_q, err_q, cross_q, err_in, legal_in, last_ack;
   logic [2:0] f3_q;
   logic [31:0] addr_q, wdata_q, lo_q, rdata_q, word0, d, ext;
   logic [3:0] mask;
   logic [7:0] be8;
   logic [63:0] w64;
   function automatic logic crosses(input logic [2:0] f3, input logic [1:0] o);
      return f3[1] ? o != 2'd0 : f3[0] & (o == 2'd3);
   endfunction
   assign legal_in = req_funct3[1:0] != 2'b11 && !(req_funct3[2] && (req_we || req_funct3[1]));
   assign err_in = !legal_in || (!ALLOW_SPLIT && crosses(req_funct3, req_addr[1:0]));
   assign cross_q = crosses(f3_q, addr_q[1:0]);
   assign last_ack = mem_ack && ((state == ACC0 && !cross_q) || state == ACC1);
   // Lane masks and store data for both phases come from one double-width shift
   assign mask = f3_q[1] ? 4'hF : f3_q[0] ? 4'h3 : 4'h1;
   assign be8 = {4'b0, mask} << addr_q[1:0];
   assign w64 = {32'b0, wdata_q} << {addr_q[1:0], 3'b0};
   assign word0 = {addr_q[31:2], 2'b00};
   assign d = 32'({state == ACC1 ? mem_rdata : 32'b0, state == ACC1 ? lo_q : mem_rdata} >> {addr_q[1:0], 3'b0});
   assign ext = f3_q[1] ? d : f3_q[0] ? {{16{d[15] & !f3_q[2]}}, d[15:0]} : {{24{d[7] & !f3_q[2]}}, d[7:0]};
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   always_comb
      state_nx = state == IDLE ? (req_valid ? (err_in ? RESP : ACC0) : IDLE) :
                 state == ACC0 ? (mem_ack ? (cross_q ? ACC1 : RESP) : ACC0) :
                 state == ACC1 ? (mem_ack ? RESP : ACC1) : IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q <= 1'b0;
         f3_q <= 3'b0;
         addr_q <= 32'b0;
         wdata_q <= 32'b0;
         lo_q <= 32'b0;
         rdata_q <= 32'b0;
         err_q <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            we_q <= req_we;
            f3_q <= req_funct3;
            addr_q <= req_addr;
            wdata_q <= req_wdata;
            err_q <= err_in;
            rdata_q <= 32'b0;
         end
         if (state == ACC0 && mem_ack) lo_q <= mem_rdata;
         if (last_ack) rdata_q <= we_q ? 32'b0 : ext;
      end
   end
   always_comb begin
      req_ready = state == IDLE;
      rsp_valid = state == RESP;
      rsp_rdata = rdata_q;
      rsp_err = err_q;
      mem_req = state == ACC0 || state == ACC1;
      mem_we = mem_req && we_q;
      mem_addr = state == ACC0 ? word0 : state == ACC1 ? word0 + 32'd4 : 32'b0;
      mem_be = state == ACC0 ? be8[3:0] : state == ACC1 ? be8[7:4] : 4'b0;
      mem_wdata = state == ACC0 ? w64[31:0] : state == ACC1 ? w64[63:32] : 32'b0;
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit, with a second
// instance built without split support for the word-crossing error case.
module tb_load_store_unit;
   logic clk = 1'b0, rst = 1'b1;
   logic req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
   logic [2:0] req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'b0, req_wdata = 32'b0, mem_rdata = 32'b0;
   logic req_ready, rsp_valid, rsp_err, mem_req, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [3:0] mem_be;
   logic req_ready_n, rsp_valid_n, rsp_err_n, mem_req_n, mem_we_n;
   logic [31:0] rsp_rdata_n, mem_addr_n, mem_wdata_n;
   logic [3:0] mem_be_n;
   int passed = 0, total = 0;
   always #5 clk = ~clk;
   load_store_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));
   load_store_unit #(.ALLOW_SPLIT(1'b0)) dut_ns (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_n), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_n), .rsp_rdata(rsp_rdata_n), .rsp_err(rsp_err_n),
      .mem_req(mem_req_n), .mem_we(mem_we_n), .mem_addr(mem_addr_n), .mem_be(mem_be_n),
      .mem_wdata(mem_wdata_n), .mem_ack(mem_ack), .mem_rdata(mem_rdata));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      req_we = we;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = wd;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask
   task automatic ack(input logic [31:0] rd);
      mem_ack = 1'b1;
      mem_rdata = rd;
      step();
      mem_ack = 1'b0;
   endtask
   initial begin
      step();
      step();
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
      rst = 1'b0;
      step();
      // SW aligned
      issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      chk("sw_req", mem_req, 1);
      chk("sw_we", mem_we, 1);
      chk("sw_addr", mem_addr, 32'h100);
      chk("sw_be", mem_be, 4'b1111);
      chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sw_no_rsp_c1", rsp_valid, 0);
      chk("sw_busy", req_ready, 0);
      ack(32'h0);
      chk("sw_rsp_c2", rsp_valid, 1);
      chk("sw_req_drop", mem_req, 0);
      chk("sw_rdata", rsp_rdata, 0);
      chk("sw_err", rsp_err, 0);
      step();
      chk("sw_rsp_pulse", rsp_valid, 0);
      chk("sw_idle", req_ready, 1);
      // LB / LBU top byte
      issue(1'b0, 3'b000, 32'h103, 32'h0);
      chk("lb_be", mem_be, 4'b1000);
      chk("lb_we", mem_we, 0);
      ack(32'h80112233);
      chk("lb_rdata", rsp_rdata, 32'hFFFFFF80);
      step();
      chk("lb_hold", rsp_rdata, 32'hFFFFFF80);
      issue(1'b0, 3'b100, 32'h103, 32'h0);
      ack(32'h80112233);
      chk("lbu_rdata", rsp_rdata, 32'h00000080);
      step();
      // LH / LHU upper half
      issue(1'b0, 3'b001, 32'h102, 32'h0);
      chk("lh_be", mem_be, 4'b1100);
      ack(32'h8001BEEF);
      chk("lh_rdata", rsp_rdata, 32'hFFFF8001);
      step();
      issue(1'b0, 3'b101, 32'h102, 32'h0);
      ack(32'h8001BEEF);
      chk("lhu_rdata", rsp_rdata, 32'h00008001);
      step();
      // LW word-crossing split
      issue(1'b0, 3'b010, 32'h102, 32'h0);
      chk("lw_a0", mem_addr, 32'h100);
      chk("lw_be0", mem_be, 4'b1100);
      ack(32'h44332211);
      chk("lw_req1", mem_req, 1);
      chk("lw_a1", mem_addr, 32'h104);
      chk("lw_be1", mem_be, 4'b0011);
      chk("lw_no_rsp", rsp_valid, 0);
      ack(32'h88776655);
      chk("lw_rsp", rsp_valid, 1);
      chk("lw_rdata", rsp_rdata, 32'h66554433);
      step();
      // SH crossing
      issue(1'b1, 3'b001, 32'h1FF, 32'h0000ABCD);
      chk("sh_a0", mem_addr, 32'h1FC);
      chk("sh_be0", mem_be, 4'b1000);
      chk("sh_wd0", mem_wdata[31:24], 8'hCD);
      ack(32'h0);
      chk("sh_a1", mem_addr, 32'h200);
      chk("sh_be1", mem_be, 4'b0001);
      chk("sh_wd1", mem_wdata[7:0], 8'hAB);
      chk("sh_we1", mem_we, 1);
      ack(32'h0);
      chk("sh_rsp", rsp_valid, 1);
      chk("sh_rdata", rsp_rdata, 0);
      step();
      // illegal funct3 and no-split error
      rst = 1'b1;
      step();
      rst = 1'b0;
      issue(1'b0, 3'b011, 32'h0, 32'h0);
      chk("ill_mem_req", mem_req, 0);
      chk("ill_rsp", rsp_valid, 1);
      chk("ill_err", rsp_err, 1);
      chk("ill_rdata", rsp_rdata, 0);
      step();
      chk("ill_err_hold", rsp_err, 1);
      issue(1'b0, 3'b010, 32'h101, 32'h0);
      chk("ns_mem_req", mem_req_n, 0);
      chk("ns_rsp", rsp_valid_n, 1);
      chk("ns_err", rsp_err_n, 1);
      chk("split_ok_req", mem_req, 1);
      ack(32'h0);
      ack(32'h0);
      chk("split_ok_err", rsp_err, 0);
      step();
      // delayed ack keeps the transaction stable
      issue(1'b0, 3'b010, 32'h100, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("dly_req", mem_req, 1);
         chk("dly_addr", mem_addr, 32'h100);
         chk("dly_be", mem_be, 4'b1111);
         chk("dly_we", mem_we, 0);
         step();
      end
      chk("dly_no_rsp", rsp_valid, 0);
      ack(32'h12345678);
      chk("dly_rsp", rsp_valid, 1);
      chk("dly_rdata", rsp_rdata, 32'h12345678);
      step();
      // reset during the second phase, then a stray ack
      issue(1'b0, 3'b010, 32'h102, 32'h0);
      ack(32'h11111111);
      chk("rst1_acc1", mem_addr, 32'h104);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst1_ready", req_ready, 1);
      chk("rst1_req", mem_req, 0);
      chk("rst1_addr", mem_addr, 0);
      chk("rst1_be", mem_be, 0);
      chk("rst1_rdata", rsp_rdata, 0);
      chk("rst1_rsp", rsp_valid, 0);
      ack(32'hFFFFFFFF);
      chk("late_rsp", rsp_valid, 0);
      chk("late_req", mem_req, 0);
      chk("late_ready", req_ready, 1);
      chk("late_rdata", rsp_rdata, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
